// File: rtl/pipeline_stall_sequencer.sv
// ============================================================================
// Module   : pipeline_stall_sequencer
// Brief    : Hazard sequencer issuing hold/flush controls to pipeline regs
//            and the PC. Optional macro STALL_STATS_EN adds a saturating
//            stall-cycle counter on port Stall_Count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_sequencer #(
    parameter int MD_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        PCSrc,
    input  logic        LoadUse_Req,
    input  logic        MulDiv_Req,
    output logic [1:0]  IF_ID_Signal,
    output logic [1:0]  ID_EX_Signal,
    output logic [1:0]  EX_MEM_Signal,
    output logic        MEM_WB_Signal,
    output logic [1:0]  PC_Write,
    output logic        MulDiv_Busy,
`ifdef STALL_STATS_EN
    output logic [1:0]  Seq_State,
    output logic [15:0] Stall_Count
`else
    output logic [1:0]  Seq_State
`endif
);

    localparam int              c_CNT_W    = $clog2(MD_LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MD_LATENCY - 2);

    localparam logic [1:0] c_NORMAL = 2'd0;
    localparam logic [1:0] c_HOLD   = 2'd1;
    localparam logic [1:0] c_FLUSH  = 2'd2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MD_BUSY    = 2'd1,
        BR_PEND    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_md_count;
    logic                 r_br_pending;
    logic                 w_md_start;

    // A new mult/div only launches from RUN when no higher-priority hazard is present.
    assign w_md_start = (r_state == RUN) && !PCSrc && !LoadUse_Req && MulDiv_Req;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= RUN;
            r_md_count   <= '0;
            r_br_pending <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_md_start) begin
                r_md_count <= c_CNT_LOAD;
            end else if (r_state == MD_BUSY && r_md_count != '0) begin
                r_md_count <= r_md_count - 1'b1;
            end
            if (r_state == MD_BUSY && PCSrc) begin
                r_br_pending <= 1'b1;
            end else if (r_state == BR_PEND) begin
                r_br_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next  = RUN;
        IF_ID_Signal  = c_NORMAL;
        ID_EX_Signal  = c_NORMAL;
        EX_MEM_Signal = c_NORMAL;
        PC_Write      = 2'd0;
        case (r_state)
            RUN: begin
                if (PCSrc) begin
                    IF_ID_Signal = c_FLUSH;
                    ID_EX_Signal = c_FLUSH;
                end else if (LoadUse_Req) begin
                    IF_ID_Signal = c_HOLD;
                    ID_EX_Signal = c_FLUSH;
                    PC_Write     = 2'd1;
                end else if (MulDiv_Req) begin
                    w_state_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                IF_ID_Signal  = c_HOLD;
                ID_EX_Signal  = c_HOLD;
                EX_MEM_Signal = c_FLUSH;
                PC_Write      = 2'd1;
                // A branch resolved on the final busy cycle still gets its flush.
                if (r_md_count != '0) begin
                    w_state_next = MD_BUSY;
                end else if (r_br_pending || PCSrc) begin
                    w_state_next = BR_PEND;
                end
            end
            BR_PEND: begin
                IF_ID_Signal = c_FLUSH;
                ID_EX_Signal = c_FLUSH;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign MEM_WB_Signal = 1'b0;
    assign MulDiv_Busy   = (r_state == MD_BUSY);
    assign Seq_State     = r_state;

`ifdef STALL_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Stall_Count <= 16'd0;
        end else if (PC_Write[0] && Stall_Count != 16'hFFFF) begin
            Stall_Count <= Stall_Count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_sequencer.sv
// ============================================================================
// Module   : tb_pipeline_stall_sequencer
// Brief    : Directed vector bench for pipeline_stall_sequencer, MD_LATENCY=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stall_sequencer;

    logic        Clk;
    logic        Rst_n;
    logic        PCSrc;
    logic        LoadUse_Req;
    logic        MulDiv_Req;
    logic [1:0]  IF_ID_Signal;
    logic [1:0]  ID_EX_Signal;
    logic [1:0]  EX_MEM_Signal;
    logic        MEM_WB_Signal;
    logic [1:0]  PC_Write;
    logic        MulDiv_Busy;
    logic [1:0]  Seq_State;
`ifdef STALL_STATS_EN
    logic [15:0] Stall_Count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_stall_sequencer #(.MD_LATENCY(4)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .PCSrc        (PCSrc),
        .LoadUse_Req  (LoadUse_Req),
        .MulDiv_Req   (MulDiv_Req),
        .IF_ID_Signal (IF_ID_Signal),
        .ID_EX_Signal (ID_EX_Signal),
        .EX_MEM_Signal(EX_MEM_Signal),
        .MEM_WB_Signal(MEM_WB_Signal),
        .PC_Write     (PC_Write),
        .MulDiv_Busy  (MulDiv_Busy),
`ifdef STALL_STATS_EN
        .Seq_State    (Seq_State),
        .Stall_Count  (Stall_Count)
`else
        .Seq_State    (Seq_State)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       pcsrc;
        logic       lu;
        logic       md;
        logic [1:0] e_ifid;
        logic [1:0] e_idex;
        logic [1:0] e_exmem;
        logic [1:0] e_pc;
        logic       e_busy;
        logic [1:0] e_state;
    } vec_t;

    localparam int N_VEC = 23;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [1:0] ifid, input logic [1:0] idex,
                             input logic [1:0] exmem, input logic [1:0] pc,
                             input logic busy, input logic [1:0] st);
        check("IF_ID",   idx, 16'(IF_ID_Signal),  16'(ifid));
        check("ID_EX",   idx, 16'(ID_EX_Signal),  16'(idex));
        check("EX_MEM",  idx, 16'(EX_MEM_Signal), 16'(exmem));
        check("MEM_WB",  idx, 16'(MEM_WB_Signal), 16'd0);
        check("PC_Write",idx, 16'(PC_Write),      16'(pc));
        check("Busy",    idx, 16'(MulDiv_Busy),   16'(busy));
        check("State",   idx, 16'(Seq_State),     16'(st));
    endtask

    function automatic vec_t mk(input logic p, input logic l, input logic m,
                                input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                                input logic [1:0] pc, input logic bz, input logic [1:0] st);
        vec_t v;
        v.pcsrc = p; v.lu = l; v.md = m;
        v.e_ifid = a; v.e_idex = b; v.e_exmem = c;
        v.e_pc = pc; v.e_busy = bz; v.e_state = st;
        return v;
    endfunction

    task automatic do_reset();
        PCSrc = 1'b0; LoadUse_Req = 1'b0; MulDiv_Req = 1'b0;
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        // One entry per cycle; the rows build on each other as a single sequence.
        //            PC LU MD  IFID IDEX EXMEM PC  BUSY ST
        vecs[0]  = mk(0, 0, 0,  0,   0,   0,    0,  0,   0);
        vecs[1]  = mk(1, 0, 0,  2,   2,   0,    0,  0,   0);
        vecs[2]  = mk(0, 1, 0,  1,   2,   0,    1,  0,   0);
        vecs[3]  = mk(1, 1, 0,  2,   2,   0,    0,  0,   0);
        vecs[4]  = mk(1, 0, 1,  2,   2,   0,    0,  0,   0);
        vecs[5]  = mk(0, 1, 1,  1,   2,   0,    1,  0,   0);
        vecs[6]  = mk(0, 0, 1,  0,   0,   0,    0,  0,   0);
        vecs[7]  = mk(0, 0, 0,  1,   1,   2,    1,  1,   1);
        vecs[8]  = mk(0, 1, 1,  1,   1,   2,    1,  1,   1);
        vecs[9]  = mk(0, 0, 0,  1,   1,   2,    1,  1,   1);
        vecs[10] = mk(0, 0, 0,  0,   0,   0,    0,  0,   0);
        vecs[11] = mk(0, 0, 1,  0,   0,   0,    0,  0,   0);
        vecs[12] = mk(0, 0, 0,  1,   1,   2,    1,  1,   1);
        vecs[13] = mk(1, 0, 0,  1,   1,   2,    1,  1,   1);
        vecs[14] = mk(0, 0, 0,  1,   1,   2,    1,  1,   1);
        vecs[15] = mk(0, 1, 1,  2,   2,   0,    0,  0,   2);
        vecs[16] = mk(0, 0, 0,  0,   0,   0,    0,  0,   0);
        vecs[17] = mk(0, 0, 1,  0,   0,   0,    0,  0,   0);
        vecs[18] = mk(0, 0, 0,  1,   1,   2,    1,  1,   1);
        vecs[19] = mk(0, 0, 0,  1,   1,   2,    1,  1,   1);
        vecs[20] = mk(1, 0, 0,  1,   1,   2,    1,  1,   1);
        vecs[21] = mk(0, 0, 0,  2,   2,   0,    0,  0,   2);
        vecs[22] = mk(0, 0, 0,  0,   0,   0,    0,  0,   0);

        PCSrc = 1'b0; LoadUse_Req = 1'b0; MulDiv_Req = 1'b0; Rst_n = 1'b0;
        #12;
        check_all(100, 0, 0, 0, 0, 0, 0);
`ifdef STALL_STATS_EN
        check("StallCnt_reset", 100, Stall_Count, 16'd0);
`endif
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            @(negedge Clk);
            PCSrc       = vecs[i].pcsrc;
            LoadUse_Req = vecs[i].lu;
            MulDiv_Req  = vecs[i].md;
            #1;
            check_all(i, vecs[i].e_ifid, vecs[i].e_idex, vecs[i].e_exmem,
                      vecs[i].e_pc, vecs[i].e_busy, vecs[i].e_state);
        end

        // Reset during the second busy cycle with a branch already pending.
        @(negedge Clk);
        PCSrc = 1'b0; LoadUse_Req = 1'b0; MulDiv_Req = 1'b1;
        @(negedge Clk);
        MulDiv_Req = 1'b0; PCSrc = 1'b1;
        #1;
        check_all(200, 1, 1, 2, 1, 1, 1);
        @(negedge Clk);
        PCSrc = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        check_all(201, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            #1;
            check_all(202 + k, 0, 0, 0, 0, 0, 0);
        end

`ifdef STALL_STATS_EN
        do_reset();
        @(negedge Clk);
        MulDiv_Req = 1'b1;
        @(negedge Clk);
        MulDiv_Req = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check("StallCnt_md", 300, Stall_Count, 16'd3);
        LoadUse_Req = 1'b1;
        repeat (70000) @(negedge Clk);
        #1;
        check("StallCnt_sat", 301, Stall_Count, 16'hFFFF);
        LoadUse_Req = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
